// File: rtl/alt_sync_ram_pkg.sv
// alt_sync_ram_pkg
// Shared constants and helpers for the alt_sync_ram simple-dual-port RAM.
//   - string values accepted by the mode parameters
//   - read_latency(): cycles from a read address to q_b for an outdata_reg_b value
package alt_sync_ram_pkg;

  localparam string DUAL_PORT_MODE    = "DUAL_PORT";
  localparam string UNREGISTERED_MODE = "UNREGISTERED";
  localparam string CLOCK0_MODE       = "CLOCK0";
  localparam string OLD_DATA_MODE     = "OLD_DATA";

  function automatic int read_latency(string outdata_reg);
    return (outdata_reg == CLOCK0_MODE) ? 2 : 1;
  endfunction

endpackage

// File: rtl/alt_sync_ram_read_port.sv
// alt_sync_ram_read_port
// Read-side pipeline of alt_sync_ram: the read-data register rd_q and, when
// out_reg is set, an extra output register out_q.
// Ports:
//   clk       - clock (clock0 of the parent)
//   rst       - synchronous active-high clear of rd_q/out_q, beats clk_en
//   clk_en    - global clock enable
//   rd_en     - read enable
//   addr_hold - address stall; rd_q holds while high
//   rd_data   - storage word already selected by the parent (pre-write value)
//   q         - read data presented to the parent's q_b
module alt_sync_ram_read_port #(
  parameter int width   = 8,
  parameter bit out_reg = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             rd_en,
  input  logic             addr_hold,
  input  logic [width-1:0] rd_data,
  output logic [width-1:0] q
);

  // Declaration initialisers give 0 on q at time zero, before any reset.
  logic [width-1:0] rd_q = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (clk_en && rd_en && !addr_hold) begin
      rd_q <= rd_data;
    end
  end

  if (out_reg) begin : g_out_reg
    logic [width-1:0] out_q = '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= '0;
      end else if (clk_en) begin
        out_q <= rd_q;
      end
    end

    assign q = out_q;
  end else begin : g_no_out_reg
    assign q = rd_q;
  end

endmodule

// File: rtl/alt_sync_ram.sv
// alt_sync_ram
// Simple-dual-port synchronous RAM, single clock: write port A, read port B.
// Read latency is 1 cycle ("UNREGISTERED") or 2 cycles ("CLOCK0").
// A read on the same edge as a write to the same address returns old data.
// Optional build macro: ALT_SYNC_RAM_ASSERT_EN enables simulation checks on
// parameters and on port usage.
// Ports:
//   clock0, clocken0, aclr0      - clock, global enable, sync active-high reset
//   wren_a, address_a, data_a    - write port
//   rden_b, address_b,
//   addressstall_b, q_b          - read port
//   q_a, eccstatus               - tied to 0
//   rden_a, wren_b, data_b, clock1, clocken1..3, aclr1, byteena_a/b,
//   addressstall_a               - accepted and ignored
module alt_sync_ram
  import alt_sync_ram_pkg::*;
#(
  parameter string operation_mode                     = DUAL_PORT_MODE,
  parameter int    width_a                            = 8,
  parameter int    width_b                            = 8,
  parameter int    widthad_a                          = 5,
  parameter int    widthad_b                          = 5,
  parameter int    numwords_a                         = 32,
  parameter int    numwords_b                         = 32,
  parameter string address_reg_b                      = CLOCK0_MODE,
  parameter string rdcontrol_reg_b                    = CLOCK0_MODE,
  parameter string outdata_reg_b                      = UNREGISTERED_MODE,
  parameter string read_during_write_mode_mixed_ports = OLD_DATA_MODE,
  parameter string intended_device_family             = ""
) (
  input  logic                 clock0,
  input  logic                 clock1,
  input  logic                 clocken0,
  input  logic                 clocken1,
  input  logic                 clocken2,
  input  logic                 clocken3,
  input  logic                 aclr0,
  input  logic                 aclr1,
  input  logic                 wren_a,
  input  logic                 rden_a,
  input  logic [widthad_a-1:0] address_a,
  input  logic [width_a-1:0]   data_a,
  input  logic                 byteena_a,
  input  logic                 addressstall_a,
  input  logic                 wren_b,
  input  logic                 rden_b,
  input  logic [widthad_b-1:0] address_b,
  input  logic [width_b-1:0]   data_b,
  input  logic                 byteena_b,
  input  logic                 addressstall_b,
  output logic [width_a-1:0]   q_a,
  output logic [width_b-1:0]   q_b,
  output logic [1:0]           eccstatus
);

  localparam logic [widthad_a:0] depth_a = (widthad_a + 1)'(numwords_a);
  localparam logic [widthad_b:0] depth_b = (widthad_b + 1)'(numwords_b);
  localparam bit                 out_reg = (read_latency(outdata_reg_b) == 2);

  // Mode strings only matter to the optional checks; folding them here keeps
  // the default build free of unused-parameter noise.
  localparam bit unused_cfg = (operation_mode == DUAL_PORT_MODE)
                           && (address_reg_b == CLOCK0_MODE)
                           && (rdcontrol_reg_b == CLOCK0_MODE)
                           && (read_during_write_mode_mixed_ports == OLD_DATA_MODE)
                           && (intended_device_family == "");

  logic unused_inputs;
  assign unused_inputs = ^{clock1, clocken1, clocken2, clocken3, aclr1, rden_a,
                           byteena_a, addressstall_a, wren_b, data_b, byteena_b};

  logic [width_a-1:0] mem [numwords_a] = '{default: '0};

  logic               in_range_a;
  logic               in_range_b;
  logic [width_b-1:0] rd_data;

  assign in_range_a = ({1'b0, address_a} < depth_a);
  assign in_range_b = ({1'b0, address_b} < depth_b);

  // Sampled combinationally before the edge, so a same-edge write is not seen.
  assign rd_data = in_range_b ? mem[address_b] : '0;

  // Storage is not touched by aclr0.
  always_ff @(posedge clock0) begin
    if (clocken0 && wren_a && in_range_a) begin
      mem[address_a] <= data_a;
    end
  end

  alt_sync_ram_read_port #(
    .width   (width_b),
    .out_reg (out_reg)
  ) u_read_port (
    .clk       (clock0),
    .rst       (aclr0),
    .clk_en    (clocken0),
    .rd_en     (rden_b),
    .addr_hold (addressstall_b),
    .rd_data   (rd_data),
    .q         (q_b)
  );

  assign q_a       = '0;
  assign eccstatus = '0;

`ifdef ALT_SYNC_RAM_ASSERT_EN
  always_ff @(posedge clock0) begin
    assert (operation_mode == DUAL_PORT_MODE)
      else $error("alt_sync_ram: unsupported operation_mode %s", operation_mode);
    assert (read_during_write_mode_mixed_ports == OLD_DATA_MODE)
      else $error("alt_sync_ram: unsupported mixed-port mode %s",
                  read_during_write_mode_mixed_ports);
    assert (width_a == width_b && widthad_a == widthad_b && numwords_a == numwords_b)
      else $error("alt_sync_ram: port A/B geometry mismatch");
    assert (wren_b !== 1'b1)
      else $error("alt_sync_ram: wren_b asserted on read-only port");
    assert (!$isunknown(wren_a))
      else $error("alt_sync_ram: X on wren_a");
    if (wren_a === 1'b1) begin
      assert (!$isunknown(address_a))
        else $error("alt_sync_ram: X on address_a during write");
      assert (in_range_a)
        else $error("alt_sync_ram: write address out of range");
    end
    if (rden_b === 1'b1) begin
      assert (in_range_b)
        else $error("alt_sync_ram: read address out of range");
    end
  end
`endif

endmodule

// File: tb/tb_alt_sync_ram.sv
module tb_alt_sync_ram;

  localparam int DEPTH = 24;

  logic       clk = 1'b0;
  logic       we = 0, re = 0, st = 0, ce = 1, clr = 0;
  logic [4:0] aa = 0, ab = 0;
  logic [7:0] da = 0;

  logic [7:0] q_u, q_r, qa_u, qa_r;
  logic [1:0] ecc_u, ecc_r;

  int tests = 0;
  int fails = 0;

  // Reference model state: storage contents and the value each q_b shows.
  int m_mem [32];
  int m_u;
  int m_r;

  always #5 clk = ~clk;

  alt_sync_ram #(.numwords_a(DEPTH), .numwords_b(DEPTH),
                 .outdata_reg_b("UNREGISTERED")) u_unreg (
    .clock0(clk), .clock1(1'b0), .clocken0(ce), .clocken1(1'b0),
    .clocken2(1'b0), .clocken3(1'b0), .aclr0(clr), .aclr1(1'b0),
    .wren_a(we), .rden_a(1'b0), .address_a(aa), .data_a(da),
    .byteena_a(1'b1), .addressstall_a(1'b0), .wren_b(1'b0), .rden_b(re),
    .address_b(ab), .data_b(8'h00), .byteena_b(1'b1), .addressstall_b(st),
    .q_a(qa_u), .q_b(q_u), .eccstatus(ecc_u));

  alt_sync_ram #(.numwords_a(DEPTH), .numwords_b(DEPTH),
                 .outdata_reg_b("CLOCK0")) u_reg (
    .clock0(clk), .clock1(1'b0), .clocken0(ce), .clocken1(1'b0),
    .clocken2(1'b0), .clocken3(1'b0), .aclr0(clr), .aclr1(1'b0),
    .wren_a(we), .rden_a(1'b0), .address_a(aa), .data_a(da),
    .byteena_a(1'b1), .addressstall_a(1'b0), .wren_b(1'b0), .rden_b(re),
    .address_b(ab), .data_b(8'h00), .byteena_b(1'b1), .addressstall_b(st),
    .q_a(qa_r), .q_b(q_r), .eccstatus(ecc_r));

  typedef struct {
    logic       we;
    logic [4:0] aa;
    logic [7:0] da;
    logic       re;
    logic [4:0] ab;
    logic       st;
    logic       ce;
    logic       clr;
    logic [7:0] exp_u;
    logic [7:0] exp_r;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, advance the model by the storage/read rules,
  // then let the edge happen and settle.
  task automatic step(input logic i_we, input logic [4:0] i_aa, input logic [7:0] i_da,
                      input logic i_re, input logic [4:0] i_ab, input logic i_st,
                      input logic i_ce, input logic i_clr);
    int old_word;
    we = i_we; aa = i_aa; da = i_da; re = i_re; ab = i_ab; st = i_st;
    ce = i_ce; clr = i_clr;
    old_word = (int'(i_ab) < DEPTH) ? m_mem[i_ab] : 0;
    if (i_clr) begin
      m_u = 0;
      m_r = 0;
    end else if (i_ce) begin
      // The 2-cycle port shows what the 1-cycle port showed one edge earlier.
      m_r = m_u;
      if (i_re && !i_st) m_u = old_word;
    end
    if (i_ce && i_we && int'(i_aa) < DEPTH) m_mem[i_aa] = int'(i_da);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [$];

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    m_u = 0;
    m_r = 0;

    //            we aa     da     re ab     st ce clr  q(1cyc) q(2cyc)
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd5,  0, 1, 0, 8'h00, 8'h00});
    vecs.push_back('{1, 5'd3,  8'hA5, 0, 5'd0,  0, 1, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd3,  0, 1, 0, 8'hA5, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd4,  0, 1, 0, 8'hA5, 8'hA5});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd4,  1, 1, 0, 8'hA5, 8'hA5});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd4,  0, 1, 0, 8'hA5, 8'hA5});
    vecs.push_back('{1, 5'd7,  8'h22, 0, 5'd0,  0, 1, 0, 8'hA5, 8'hA5});
    vecs.push_back('{1, 5'd7,  8'h11, 1, 5'd7,  0, 1, 0, 8'h22, 8'hA5});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd7,  0, 1, 0, 8'h11, 8'h22});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd0,  0, 1, 0, 8'h11, 8'h11});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd3,  0, 1, 0, 8'hA5, 8'h11});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd0,  0, 1, 0, 8'hA5, 8'hA5});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd3,  0, 1, 1, 8'h00, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd3,  0, 1, 0, 8'hA5, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd0,  0, 1, 0, 8'hA5, 8'hA5});
    vecs.push_back('{1, 5'd5,  8'hFF, 1, 5'd3,  0, 0, 0, 8'hA5, 8'hA5});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd5,  0, 1, 0, 8'h00, 8'hA5});
    vecs.push_back('{1, 5'd5,  8'hFF, 0, 5'd0,  0, 1, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd5,  0, 1, 0, 8'hFF, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd0,  0, 1, 0, 8'hFF, 8'hFF});
    vecs.push_back('{1, 5'd25, 8'h77, 0, 5'd0,  0, 1, 0, 8'hFF, 8'hFF});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd25, 0, 1, 0, 8'h00, 8'hFF});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd0,  0, 1, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd5,  0, 1, 0, 8'hFF, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd0,  0, 1, 0, 8'hFF, 8'hFF});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd5,  0, 0, 1, 8'h00, 8'h00});
    vecs.push_back('{1, 5'd9,  8'h3C, 0, 5'd0,  0, 1, 1, 8'h00, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 1, 5'd9,  0, 1, 0, 8'h3C, 8'h00});
    vecs.push_back('{0, 5'd0,  8'h00, 0, 5'd0,  0, 1, 0, 8'h3C, 8'h3C});

    #1;
    check("time0_q_unreg", q_u, 8'h00);
    check("time0_q_reg", q_r, 8'h00);
    check("time0_q_a", qa_u, 8'h00);
    check("time0_ecc", {6'd0, ecc_r}, 8'h00);

    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("reset_q_unreg", q_u, 8'h00);
    check("reset_q_reg", q_r, 8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].aa, vecs[i].da, vecs[i].re, vecs[i].ab,
           vecs[i].st, vecs[i].ce, vecs[i].clr);
      check($sformatf("vec%0d_q_unreg", i), q_u, vecs[i].exp_u);
      check($sformatf("vec%0d_q_reg", i), q_r, vecs[i].exp_r);
    end

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 31) == 0));
      check("rand_q_unreg", q_u, 8'(m_u));
      check("rand_q_reg", q_r, 8'(m_r));
    end

    check("tie_q_a", qa_r, 8'h00);
    check("tie_ecc", {6'd0, ecc_u}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alt_sync_ram.md
# alt_sync_ram

Synchronous simple-dual-port block RAM model: one write port (A), one read port (B), single clock. It is the storage primitive under the MPF simple-RAM wrappers; those wrappers rely on its fixed 1- or 2-cycle read latency and on old-data mixed-port read-during-write behaviour for their bypass logic.

## Interface
- `operation_mode`, default "DUAL_PORT": only supported value.
- `width_a` / `width_b`, default 8: data width; must be equal.
- `widthad_a` / `widthad_b`, default 5: address width; must be equal.
- `numwords_a` / `numwords_b`, default 32: depth, at most 2^widthad; must be equal.
- `address_reg_b` / `rdcontrol_reg_b`, default "CLOCK0": read address and rden_b are registered on clock0.
- `outdata_reg_b`, default "UNREGISTERED": "UNREGISTERED" gives 1-cycle read latency; "CLOCK0" adds an output register for 2-cycle latency.
- `read_during_write_mode_mixed_ports`, default "OLD_DATA": only supported value.
- `intended_device_family`, default "": accepted and ignored.
- `clock0` input, 1 bit: the single clock; all state changes on its rising edge.
- `aclr0` input, 1 bit: reset, synchronous and active-high.
- `wren_a` input, 1 bit: write enable.
- `address_a` input, widthad_a bits: write address.
- `data_a` input, width_a bits: write data.
- `address_b` input, widthad_b bits: read address.
- `rden_b` input, 1 bit: read enable.
- `addressstall_b` input, 1 bit: holds the read-address register.
- `clocken0` input, 1 bit: global enable for clock0.
- `q_b` output, width_b bits: read data.
- Ignored inputs: `rden_a`, `wren_b`, `data_b`, `clock1`, `clocken1..3`, `aclr1`, `byteena_a`, `byteena_b`, `addressstall_a`.
- Tied outputs: `q_a` is 0; `eccstatus` (2 bits) is 0.

## Operation
- Storage is `numwords_a` words of `width_a` bits, initialised to 0 at time zero. Reset does not clear storage.
- Write: on an edge with clocken0 and wren_a high, mem[address_a] is loaded with data_a. Byte enables are treated as all-ones.
- Read stage 1: on an edge with clocken0 and rden_b high and addressstall_b low, rd_q is loaded with mem[address_b], using the value before any same-edge write (OLD_DATA).
  - If rden_b is low or addressstall_b is high, rd_q holds.
- Read stage 2 ("CLOCK0" only): on an edge with clocken0 high, out_q is loaded with rd_q.
- q_b equals rd_q in "UNREGISTERED" mode and out_q in "CLOCK0" mode.
- Out-of-range addresses (at or above numwords): writes are dropped and reads load 0.
- aclr0 high at an edge: rd_q and out_q are cleared to 0, overriding both clocken0 and the read. A write in the same cycle is still performed.

## Timing
- Latency: a read address presented before edge N appears on q_b after edge N ("UNREGISTERED") or after edge N+1 ("CLOCK0").
- Write followed by read of the same address:
  - Same edge: read returns the old value.
  - Read one edge later: read returns the new value.
- q_b holds its value between enabled reads.
- Output values while and after reset: q_b is 0 from the edge after aclr0 is sampled high. Reads resume on the first edge with aclr0 low.
- Every output is 0 after reset, and also at time zero.

## Configuration
- `ALT_SYNC_RAM_ASSERT_EN`: when defined, simulation assertions fire on any of:
  - an unsupported operation_mode or mixed-port mode;
  - mismatched port A and port B widths or depths;
  - wren_b high;
  - an out-of-range address used while its enable is high;
  - X on wren_a, or on address_a while wren_a is high.
- When undefined, no checks are compiled and behaviour is otherwise identical.

## Structure
- Package `alt_sync_ram_pkg` holds:
  - string constants for the supported mode values ("DUAL_PORT", "UNREGISTERED", "CLOCK0", "OLD_DATA");
  - a function returning the read latency for a given outdata_reg_b value.
- Sub-module `alt_sync_ram_read_port` contains rd_q, optional out_q, and their enable and reset logic. The top level holds the array, the write logic, tie-offs and assertions.

## Test plan
- UNREGISTERED mode, widths 8/5:
  - Write 0xA5 to address 3, then read address 3 on the next cycle: q_b is 0xA5 one edge after the read address.
  - Repeat with "CLOCK0": q_b is 0xA5 two edges after the read address.
- Same-edge write of 0x11 to address 7 (old value 0x22) while reading address 7: q_b shows 0x22. Reading address 7 again on the next cycle shows 0x11.
- rden_b low, or addressstall_b high, with address_b changed from 3 to 4: q_b holds 0xA5.
- aclr0 pulsed for one cycle after 0xA5 is visible:
  - q_b is 0 on the following cycle;
  - re-reading address 3 gives 0xA5 again, because storage is preserved.
- clocken0 low during a write of 0xFF to address 5: address 5 still reads 0x00 afterwards. The same write with clocken0 high then reads 0xFF.
